instruction_encoder: RTL
========================

// Module: instruction_encoder
// PURPOSE
//  Inverse of the ID-stage immediate extraction: inserts a 32-bit immediate into the format-specific bit
//  fields of a caller-supplied base instruction word (opcode/rd/rs1/rs2/funct already set).
//  Streams encoded words with sequential IMEM write addresses for the boot/test program loader.
//  Sits between the loader front end (valid/ready) and the IMEM write port.
// PARAMETERS
//  DATA_WIDTH  32           instruction/immediate width (from core_pkg; only 32 supported)
//  ADDR_WIDTH  12           IMEM byte-address width of addr_o
//  BASE_ADDR   '0           first write address after reset/flush; must be 4-byte aligned
//  ERR_CNT_W   8            width of saturating error counter
// PORTS
//  clk          in   1            core clock
//  rst_n        in   1            asynchronous active-low reset
//  flush_i      in   1            sync: drop pending word, reload address to BASE_ADDR, clear err count
//  valid_i      in   1            input word valid
//  ready_o      out  1            encoder can accept input
//  base_i       in   DATA_WIDTH   base instruction, immediate bit positions ignored
//  imm_i        in   DATA_WIDTH   immediate value (byte offset for B/J, full value for U)
//  ImmSel_i     in   imm_sel_e    format selector (core_pkg)
//  valid_o      out  1            encoded word valid
//  ready_i      in   1            downstream accepts word
//  instr_o      out  DATA_WIDTH   encoded instruction
//  addr_o       out  ADDR_WIDTH   IMEM byte address of instr_o
//  err_o        out  1            range error flag travelling with instr_o
//  err_cnt_o    out  ERR_CNT_W    saturating count of transferred words with err_o=1
// BEHAVIOUR
//  Reset (async, rst_n=0): valid_o=0, instr_o=0, addr_o=BASE_ADDR, err_o=0, err_cnt_o=0; ready_o=1 after.
//  Single output register, latency 1: word accepted on cycle N (valid_i&ready_o) appears on valid_o at N+1.
//  ready_o = !valid_o | ready_i (full throughput, combinational from ready_i; no comb path valid_i->valid_o).
//  Output held stable while valid_o&!ready_i. Output transfer (valid_o&ready_i): addr_o += 4, wraps mod 2^ADDR_WIDTH.
//  Simultaneous transfer-out and accept: new word loaded, valid_o stays 1, addr_o already advanced.
//  Field insertion (all other bits copied from base_i):
//   IMM_ITYPE/LOGICAL: [31:20]=imm[11:0]          IMM_STYPE: [31:25]=imm[11:5], [11:7]=imm[4:0]
//   IMM_BTYPE: [31]=imm[12],[30:25]=imm[10:5],[11:8]=imm[4:1],[7]=imm[11]
//   IMM_UTYPE: [31:12]=imm[31:12]                 IMM_JTYPE: [31]=imm[20],[30:21]=imm[10:1],[20]=imm[11],[19:12]=imm[19:12]
//   unlisted selector: instr = base_i unchanged.
//  flush_i has priority over every handshake in the same cycle; valid_i ignored while flush_i=1.
//  err_cnt_o increments on output transfer with err_o=1, saturates at all-ones.
// CONFIGURATION
//  IMM_RANGE_CHECK_EN defined: err_o=1 when immediate not exactly representable:
//   I/S: imm[31:11] not all equal; LOGICAL: imm[31:12]!=0; B: imm[31:12] not all equal or imm[0]=1;
//   J: imm[31:20] not all equal or imm[0]=1; U: imm[11:0]!=0; unlisted selector: always 1.
//   Word still encoded (truncated bits dropped) and still transferred.
//  Not defined: no check logic; err_o and err_cnt_o tied to 0; excess bits silently truncated.
// STRUCTURE
//  core_pkg: imm_sel_e (existing), new localparam INSTR_BYTES=4.
//  Sub-module imm_field_packer: pure combinational (base, imm, sel) -> (instr, range_err); top holds
//  handshake register, address counter, error counter.
// TESTING
//  ITYPE base=0x00000093 imm=0xFFFFFFFF -> instr_o=0xFFF00093, err_o=0, addr_o=BASE_ADDR.
//  STYPE base=0x00112023 imm=0xFFFFFFFC -> 0xFE112E23; BTYPE base=0x00000063 imm=8 -> 0x00000463.
//  JTYPE base=0x0000006F imm=0x800 -> 0x0010006F; UTYPE base=0x000000B7 imm=0x12345000 -> 0x123450B7.
//  Range (EN defined): ITYPE imm=0x800 -> err_o=1, err_cnt_o 0->1; BTYPE imm=6+1 -> err_o=1; undefined: err_o=0.
//  Back-pressure: 3 words, ready_i low 4 cycles -> instr_o/addr_o stable, ready_o=0; release -> addrs 0,4,8.
//  Wrap/flush/reset: ADDR_WIDTH=4, 5 transfers -> addr_o 0,4,8,C,0; flush_i with valid_o=1 -> valid_o=0,
//   addr_o=BASE_ADDR next cycle; rst_n low mid-stall -> all outputs to reset values immediately.

Source files
------------

// File: rtl/core_pkg.sv
// Shared core types: immediate format selector and instruction size constants.
package core_pkg;

    typedef enum logic [2:0] {
        IMM_ITYPE   = 3'd0,
        IMM_LOGICAL = 3'd1,
        IMM_STYPE   = 3'd2,
        IMM_BTYPE   = 3'd3,
        IMM_UTYPE   = 3'd4,
        IMM_JTYPE   = 3'd5,
        IMM_NONE    = 3'd7
    } imm_sel_e;

    localparam int INSTR_BYTES = 4;

endpackage

// File: rtl/imm_field_packer.sv
// Combinational immediate insertion into a base instruction word, the inverse of ID-stage extraction.
// Optional representability check enabled by IMM_RANGE_CHECK_EN.
module imm_field_packer
    import core_pkg::*;
(
    input  logic [31:0] base,
    input  logic [31:0] imm,
    input  imm_sel_e    sel,
    output logic [31:0] instr
`ifdef IMM_RANGE_CHECK_EN
    ,
    output logic        range_err
`endif
);

    always_comb begin
        instr = base;
        case (sel)
            IMM_ITYPE, IMM_LOGICAL: begin
                instr[31:20] = imm[11:0];
            end
            IMM_STYPE: begin
                instr[31:25] = imm[11:5];
                instr[11:7]  = imm[4:0];
            end
            IMM_BTYPE: begin
                instr[31]    = imm[12];
                instr[30:25] = imm[10:5];
                instr[11:8]  = imm[4:1];
                instr[7]     = imm[11];
            end
            IMM_UTYPE: begin
                instr[31:12] = imm[31:12];
            end
            IMM_JTYPE: begin
                instr[31]    = imm[20];
                instr[30:21] = imm[10:1];
                instr[20]    = imm[11];
                instr[19:12] = imm[19:12];
            end
            default: ;
        endcase
    end

`ifdef IMM_RANGE_CHECK_EN
    // Signed formats need the dropped upper bits to be a pure sign extension.
    always_comb begin
        range_err = 1'b1;
        case (sel)
            IMM_ITYPE, IMM_STYPE: range_err = !((&imm[31:11]) || !(|imm[31:11]));
            IMM_LOGICAL:          range_err = |imm[31:12];
            IMM_BTYPE:            range_err = !((&imm[31:12]) || !(|imm[31:12])) || imm[0];
            IMM_JTYPE:            range_err = !((&imm[31:20]) || !(|imm[31:20])) || imm[0];
            IMM_UTYPE:            range_err = |imm[11:0];
            default:              range_err = 1'b1;
        endcase
    end
`endif

endmodule

// File: rtl/instruction_encoder.sv
// Streams encoded instruction words with sequential IMEM byte addresses through a one-deep output register.
// IMM_RANGE_CHECK_EN adds a per-word range error flag and a saturating error counter.
module instruction_encoder
    import core_pkg::*;
#(
    parameter int                    DATA_WIDTH = 32,
    parameter int                    ADDR_WIDTH = 12,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0,
    parameter int                    ERR_CNT_W  = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  flush_i,
    input  logic                  valid_i,
    output logic                  ready_o,
    input  logic [DATA_WIDTH-1:0] base_i,
    input  logic [DATA_WIDTH-1:0] imm_i,
    input  imm_sel_e              ImmSel_i,
    output logic                  valid_o,
    input  logic                  ready_i,
    output logic [DATA_WIDTH-1:0] instr_o,
    output logic [ADDR_WIDTH-1:0] addr_o,
    output logic                  err_o,
    output logic [ERR_CNT_W-1:0]  err_cnt_o
);

    logic [DATA_WIDTH-1:0] packed_instr;
    logic                  accept;
    logic                  xfer;

    assign ready_o = !valid_o || ready_i;
    assign accept  = valid_i && ready_o && !flush_i;
    assign xfer    = valid_o && ready_i;

`ifdef IMM_RANGE_CHECK_EN
    logic packed_err;

    imm_field_packer u_packer (
        .base      (base_i),
        .imm       (imm_i),
        .sel       (ImmSel_i),
        .instr     (packed_instr),
        .range_err (packed_err)
    );
`else
    imm_field_packer u_packer (
        .base  (base_i),
        .imm   (imm_i),
        .sel   (ImmSel_i),
        .instr (packed_instr)
    );
`endif

    // Address advances on every transfer out, so a simultaneous reload already sees the next slot.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_o <= 1'b0;
            instr_o <= '0;
            addr_o  <= BASE_ADDR;
        end else if (flush_i) begin
            valid_o <= 1'b0;
            instr_o <= '0;
            addr_o  <= BASE_ADDR;
        end else begin
            if (xfer) begin
                addr_o <= addr_o + ADDR_WIDTH'(INSTR_BYTES);
            end
            if (accept) begin
                valid_o <= 1'b1;
                instr_o <= packed_instr;
            end else if (xfer) begin
                valid_o <= 1'b0;
            end
        end
    end

`ifdef IMM_RANGE_CHECK_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_o     <= 1'b0;
            err_cnt_o <= '0;
        end else if (flush_i) begin
            err_o     <= 1'b0;
            err_cnt_o <= '0;
        end else begin
            if (xfer && err_o && !(&err_cnt_o)) begin
                err_cnt_o <= err_cnt_o + 1'b1;
            end
            if (accept) begin
                err_o <= packed_err;
            end else if (xfer) begin
                err_o <= 1'b0;
            end
        end
    end
`else
    assign err_o     = 1'b0;
    assign err_cnt_o = '0;
`endif

endmodule
